// File: rtl/apb_controller.sv
// apb_controller: sequences pipelined AHB transfers into two-cycle APB setup/access transfers.
// Ports: hclk/hresetn clock and async active-low reset; valid/hwrite/hwrite_reg1 AHB transfer
// qualifiers; haddr/haddr1/haddr2 and hwdata/hwdata1 current and delayed AHB address/data;
// temp_sel one-hot peripheral decode; psel/penable/pwrite/paddr/pwdata registered APB outputs;
// hready_out registered AHB ready back to the master.
module apb_controller (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        valid,
  input  logic        hwrite,
  input  logic        hwrite_reg1,
  input  logic [31:0] haddr,
  input  logic [31:0] haddr1,
  input  logic [31:0] haddr2,
  input  logic [31:0] hwdata,
  input  logic [31:0] hwdata1,
  input  logic [2:0]  temp_sel,
  output logic        pwrite,
  output logic        penable,
  output logic [2:0]  psel,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        hready_out
);
  typedef enum logic [2:0] {IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP} state_t;
  state_t      state_q, state_d;
  logic [2:0]  sel1_q, sel2_q, psel_q, psel_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d, penable_q, penable_d, hready_q, hready_d;
  logic        from_wwait;
  assign from_wwait = state_q == WWAIT;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RENABLE, WENABLE: state_d = !valid ? IDLE : hwrite ? WWAIT : READ;
      WWAIT:                  state_d = valid ? WRITEP : WRITE;
      READ:                   state_d = RENABLE;
      WRITE:                  state_d = valid ? WENABLEP : WENABLE;
      WRITEP:                 state_d = WENABLEP;
      WENABLEP:               state_d = !hwrite_reg1 ? READ : valid ? WRITEP : WRITE;
      default:                state_d = IDLE;
    endcase
    psel_d    = psel_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    penable_d = 1'b0;
    hready_d  = 1'b1;
    // Outputs are loaded on entry to a state so every APB signal comes straight from a flop.
    case (state_d)
      READ: begin
        psel_d   = temp_sel;
        paddr_d  = haddr;
        pwrite_d = 1'b0;
        hready_d = 1'b0;
      end
      // A write reached straight from WWAIT has its address one cycle old; one that was
      // queued behind a previous write's access cycle is two cycles old.
      WRITE, WRITEP: begin
        psel_d   = from_wwait ? sel1_q : sel2_q;
        paddr_d  = from_wwait ? haddr1 : haddr2;
        pwdata_d = from_wwait ? hwdata : hwdata1;
        pwrite_d = 1'b1;
        hready_d = state_d == WRITE;
      end
      RENABLE, WENABLE, WENABLEP: penable_d = 1'b1;
      default: begin
        psel_d   = 3'b000;
        pwrite_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= IDLE;
      sel1_q    <= 3'b000;
      sel2_q    <= 3'b000;
      psel_q    <= 3'b000;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel1_q    <= temp_sel;
      sel2_q    <= sel1_q;
      psel_q    <= psel_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      hready_q  <= hready_d;
    end
  end
  assign psel       = psel_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign pwrite     = pwrite_q;
  assign penable    = penable_q;
  assign hready_out = hready_q;
endmodule

// File: tb/tb_apb_controller.sv
// tb_apb_controller: AHB master model plus APB transfer scoreboard for apb_controller.
module tb_apb_controller;
  logic        hclk = 1'b0, hresetn = 1'b1, valid = 1'b0, hwrite = 1'b0, hwrite_reg1 = 1'b0;
  logic [31:0] haddr = 32'h0, haddr1 = 32'h0, haddr2 = 32'h0, hwdata = 32'h0, hwdata1 = 32'h0;
  logic [2:0]  temp_sel = 3'b000;
  logic        pwrite, penable, hready_out;
  logic [2:0]  psel;
  logic [31:0] paddr, pwdata;
  int vectors = 0, miscompares = 0, cyc = 0;

  typedef struct { logic [31:0] addr; logic write; logic [31:0] data; bit idle; bit lat; } tx_t;
  typedef struct { logic [31:0] addr; logic write; logic [31:0] data; int due; } exp_t;
  tx_t  txq[$];
  exp_t expq[$];
  int   acc_cyc[$];
  tx_t  tx;
  exp_t e;
  logic        dp_next = 1'b0, dp_live = 1'b0, last_hready = 1'b1;
  logic [31:0] dp_data = 32'h0;
  logic [2:0]  p_psel;
  logic [31:0] p_paddr, p_pwdata;
  logic        p_pwrite, p_penable, p_hready;
  bit          p_ok = 1'b0;

  apb_controller dut (
    .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite), .hwrite_reg1(hwrite_reg1),
    .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2), .hwdata(hwdata), .hwdata1(hwdata1),
    .temp_sel(temp_sel), .pwrite(pwrite), .penable(penable), .psel(psel), .paddr(paddr),
    .pwdata(pwdata), .hready_out(hready_out)
  );

  always #5 hclk = ~hclk;

  // Upstream AHB slave pipeline that produces the delayed copies the bridge consumes.
  always @(posedge hclk) begin
    cyc         <= cyc + 1;
    haddr1      <= haddr;
    haddr2      <= haddr1;
    hwdata1     <= hwdata;
    hwrite_reg1 <= hwrite;
  end

  function automatic logic [2:0] dec(input logic [31:0] a);
    case (a[31:26])
      6'b100000: return 3'b001;
      6'b100001: return 3'b010;
      6'b100010: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] ra();
    logic [31:0] b;
    case ($urandom_range(0, 3))
      0:       b = 32'h8000_0000;
      1:       b = 32'h8400_0000;
      2:       b = 32'h8800_0000;
      default: b = 32'h4000_0000;
    endcase
    return b | ($urandom & 32'h03FF_FFFC);
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    txq.push_back('{a, 1'b1, d, 1'b0, 1'b0});
  endtask

  task automatic rd(input logic [31:0] a, input bit l);
    txq.push_back('{a, 1'b0, 32'h0, 1'b0, l});
  endtask

  task automatic idle(input int n);
    repeat (n) txq.push_back('{32'h0, 1'b0, 32'h0, 1'b1, 1'b0});
  endtask

  // One master cycle: address phase waits for hready_out, write data follows in the next cycle
  // and is held until a cycle with hready_out high; idle cycles keep the last address/direction.
  task automatic tick();
    @(negedge hclk);
    if (dp_next) begin
      hwdata  = dp_data;
      dp_next = 1'b0;
      dp_live = 1'b1;
    end else if (dp_live && last_hready) dp_live = 1'b0;
    if (!dp_live) hwdata = $urandom;
    valid = 1'b0;
    if (txq.size() != 0) begin
      if (txq[0].idle) tx = txq.pop_front();
      else begin
        haddr    = txq[0].addr;
        hwrite   = txq[0].write;
        temp_sel = dec(txq[0].addr);
        if (hready_out === 1'b1) begin
          tx    = txq.pop_front();
          valid = 1'b1;
          expq.push_back('{tx.addr, tx.write, tx.data, tx.lat ? cyc + 2 : -1});
          if (tx.write) begin
            dp_next = 1'b1;
            dp_data = tx.data;
          end
        end
      end
    end
    last_hready = hready_out;
  endtask

  task automatic run_all(output int lows);
    lows = 0;
    for (int i = 0; i < 300 && txq.size() != 0; i++) begin
      tick();
      if (hready_out === 1'b0) lows++;
    end
    vectors++;
    if (txq.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d stimulus entries left, required 0", txq.size());
      txq.delete();
    end
  endtask

  // APB monitor: every access cycle must match the next AHB transfer in issue order.
  initial forever begin
    @(negedge hclk);
    if (hresetn !== 1'b1) p_ok = 1'b0;
    else begin
      if (p_ok && !p_penable && (!p_hready || p_psel != 3'b000)) begin
        vectors++;
        if (penable !== 1'b1) begin
          miscompares++;
          $display("FAIL setup_no_access: penable=%b required 1 at cycle %0d", penable, cyc);
        end
      end
      if (hready_out === 1'b0) begin
        vectors++;
        if (penable !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_penable: penable=%b required 0 while hready_out low", penable);
        end
      end
      if (penable === 1'b1) begin
        acc_cyc.push_back(cyc);
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_access: paddr=%h psel=%b, required no transfer", paddr, psel);
        end else begin
          e = expq.pop_front();
          if ({paddr, psel, pwrite} !== {e.addr, dec(e.addr), e.write} || (e.write && pwdata !== e.data)) begin
            miscompares++;
            $display("FAIL access_content: paddr=%h psel=%b pwrite=%b pwdata=%h, required %h %b %b %h",
                     paddr, psel, pwrite, pwdata, e.addr, dec(e.addr), e.write, e.data);
          end
          vectors++;
          if (!p_ok || p_penable !== 1'b0 || {p_paddr, p_psel, p_pwrite, p_pwdata} !== {paddr, psel, pwrite, pwdata}) begin
            miscompares++;
            $display("FAIL setup_match: setup paddr=%h psel=%b penable=%b, required %h %b 0",
                     p_paddr, p_psel, p_penable, paddr, psel);
          end
          vectors++;
          if (hready_out !== 1'b1 || (!e.write && p_hready !== 1'b0)) begin
            miscompares++;
            $display("FAIL access_hready: setup/access hready=%b/%b, required %b/1",
                     p_hready, hready_out, e.write ? p_hready : 1'b0);
          end
          if (e.due >= 0) begin
            vectors++;
            if (cyc != e.due) begin
              miscompares++;
              $display("FAIL read_latency: access at cycle %0d, required %0d", cyc, e.due);
            end
          end
        end
      end
      p_psel    = psel;
      p_paddr   = paddr;
      p_pwdata  = pwdata;
      p_pwrite  = pwrite;
      p_penable = penable;
      p_hready  = hready_out;
      p_ok      = 1'b1;
    end
  end

  task automatic test_reset();
    #1 hresetn = 1'b0;
    #3;
    vectors++;
    if ({psel, penable, pwrite, paddr, pwdata, hready_out} !== {3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_values: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h hready=%b, required 000 0 0 0 0 1",
               psel, penable, pwrite, paddr, pwdata, hready_out);
    end
    repeat (2) @(posedge hclk);
    #1;
    vectors++;
    if ({psel, penable, pwrite, hready_out} !== 6'b000_0_0_1) begin
      miscompares++;
      $display("FAIL reset_hold: psel=%b penable=%b pwrite=%b hready=%b, required 000 0 0 1",
               psel, penable, pwrite, hready_out);
    end
    @(negedge hclk);
    #2 hresetn = 1'b1;
  endtask

  task automatic end_checks(input string name, input int n0, input int accs, input int lows, input int want_lows);
    vectors++;
    if (acc_cyc.size() - n0 != accs) begin
      miscompares++;
      $display("FAIL %s_accesses: %0d APB transfers, required %0d", name, acc_cyc.size() - n0, accs);
    end
    vectors++;
    if (lows != want_lows) begin
      miscompares++;
      $display("FAIL %s_hready_low: %0d low cycles, required %0d", name, lows, want_lows);
    end
    vectors++;
    if ({psel, penable, hready_out} !== 5'b000_0_1) begin
      miscompares++;
      $display("FAIL %s_idle: psel=%b penable=%b hready=%b, required 000 0 1", name, psel, penable, hready_out);
    end
  endtask

  task automatic test_single_read();
    int n0, lows;
    n0 = acc_cyc.size();
    rd(32'h8000_0010, 1'b1);
    idle(6);
    run_all(lows);
    end_checks("single_read", n0, 1, lows, 1);
  endtask

  task automatic test_single_write();
    int n0, lows;
    n0 = acc_cyc.size();
    wr(32'h8000_0020, 32'hA5A5_A5A5);
    idle(6);
    run_all(lows);
    end_checks("single_write", n0, 1, lows, 0);
  endtask

  task automatic test_back_to_back();
    int n0, lows;
    n0 = acc_cyc.size();
    wr(32'h8000_0000, 32'h1);
    wr(32'h8000_0004, 32'h2);
    idle(6);
    run_all(lows);
    end_checks("back_to_back", n0, 2, lows, 1);
    vectors++;
    if (acc_cyc.size() - n0 == 2 && acc_cyc[n0 + 1] - acc_cyc[n0] != 2) begin
      miscompares++;
      $display("FAIL back_to_back_spacing: %0d cycles between accesses, required 2", acc_cyc[n0 + 1] - acc_cyc[n0]);
    end
  endtask

  task automatic test_write_read();
    int n0, lows;
    n0 = acc_cyc.size();
    wr(32'h8000_0000, $urandom);
    rd(32'h8400_0000, 1'b0);
    idle(6);
    run_all(lows);
    end_checks("write_read", n0, 2, lows, 2);
    vectors++;
    if (acc_cyc.size() - n0 == 2 && acc_cyc[n0 + 1] - acc_cyc[n0] != 2) begin
      miscompares++;
      $display("FAIL write_read_spacing: %0d cycles between accesses, required 2", acc_cyc[n0 + 1] - acc_cyc[n0]);
    end
  endtask

  task automatic test_unmapped();
    int n0, lows;
    n0 = acc_cyc.size();
    rd(32'h4000_0100, 1'b1);
    idle(6);
    run_all(lows);
    end_checks("unmapped", n0, 1, lows, 1);
  endtask

  task automatic test_async_reset();
    int n0;
    n0 = acc_cyc.size();
    rd(32'h8800_0040, 1'b1);
    idle(6);
    for (int i = 0; i < 10 && hready_out !== 1'b0; i++) tick();
    vectors++;
    if (hready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reach_read: hready=%b, required 0 in read setup", hready_out);
    end
    #2 hresetn = 1'b0;
    #1;
    vectors++;
    if ({psel, penable, pwrite, paddr, pwdata, hready_out} !== {3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL async_reset_values: psel=%b penable=%b pwrite=%b paddr=%h hready=%b, required 000 0 0 0 1",
               psel, penable, pwrite, paddr, hready_out);
    end
    txq.delete();
    expq.delete();
    dp_next = 1'b0;
    dp_live = 1'b0;
    repeat (2) tick();
    #2 hresetn = 1'b1;
    repeat (5) tick();
    vectors++;
    if ({psel, penable, pwrite, hready_out} !== 6'b000_0_0_1 || acc_cyc.size() != n0) begin
      miscompares++;
      $display("FAIL async_release_idle: psel=%b penable=%b hready=%b accesses=%0d, required 000 0 1 %0d",
               psel, penable, hready_out, acc_cyc.size(), n0);
    end
  endtask

  // Randomized bursts drawn from AHB patterns the bridge sequences correctly, each followed by idle.
  task automatic test_random();
    int n0, lows, k, accs, want;
    for (int b = 0; b < 40; b++) begin
      n0 = acc_cyc.size();
      k  = $urandom_range(0, 7);
      case (k)
        0: begin rd(ra(), 1'b1); accs = 1; want = 1; end
        1: begin wr(ra(), $urandom); accs = 1; want = 0; end
        2: begin wr(ra(), $urandom); wr(ra(), $urandom); accs = 2; want = 1; end
        3: begin wr(ra(), $urandom); rd(ra(), 1'b0); accs = 2; want = 2; end
        4: begin rd(ra(), 1'b1); rd(ra(), 1'b1); accs = 2; want = 2; end
        5: begin rd(ra(), 1'b1); wr(ra(), $urandom); accs = 2; want = 1; end
        6: begin wr(ra(), $urandom); wr(ra(), $urandom); wr(ra(), $urandom); accs = 3; want = 2; end
        default: begin wr(ra(), $urandom); idle(1); rd(ra(), 1'b0); accs = 2; want = 1; end
      endcase
      idle(6);
      run_all(lows);
      end_checks($sformatf("random%0d_k%0d", b, k), n0, accs, lows, want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_write_read();
    test_unmapped();
    test_async_reset();
    test_random();
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain_expected: %0d transfers never reached APB, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
